// File: rtl/seq_pattern_gen_if.sv
// Load handshake bundle for seq_pattern_gen.
// Master offers a pattern word; slave accepts on valid && ready.
interface seq_pattern_gen_if #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [PAT_W-1:0] load_pattern;
   logic [LEN_W-1:0] load_len;
   logic [REP_W-1:0] load_reps;

   modport master (
      output load_valid,
      output load_pattern,
      output load_len,
      output load_reps,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_pattern,
      input  load_len,
      input  load_reps,
      output load_ready
   );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: loads a word, shifts its active
// window out MSB first, with stall, repeat and abort support.
module seq_pattern_gen #(
   parameter int   PAT_W      = 8,
   parameter int   LEN_W      = 4,
   parameter int   REP_W      = 4,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_pattern_gen_if.slave load,
   input  logic            bit_en,
   input  logic            abort,
   output logic            c_out,
   output logic            c_valid,
   output logic            busy,
   output logic            done
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [PAT_W-1:0]   r_pat;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   r_idx;
   logic [REP_W-1:0]   r_reps;
   logic               r_c_out;
   logic               r_c_valid;
   logic               r_busy;
   logic               r_done;
   logic               r_ready;

   state_t             w_state;
   logic [PAT_W-1:0]   w_pat;
   logic [IDX_W-1:0]   w_last;
   logic [IDX_W-1:0]   w_idx;
   logic [REP_W-1:0]   w_reps;
   logic               w_c_out;
   logic               w_c_valid;
   logic               w_busy;
   logic               w_done;
   logic               w_ready;

   logic               w_accept;
   logic [LEN_W-1:0]   w_ld_len;
   logic [IDX_W-1:0]   w_ld_last;
   logic [REP_W-1:0]   w_ld_reps;
   logic [IDX_W-1:0]   w_idx_dn;

   // Load qualification: clamp length, map reps==0 to one pass.
   always_comb begin
      w_accept = load.load_valid && r_ready && !abort;
      if (load.load_len > LEN_W'(PAT_W)) begin
         w_ld_len = LEN_W'(PAT_W);
      end else begin
         w_ld_len = load.load_len;
      end
      w_ld_last = IDX_W'(w_ld_len - LEN_W'(1));
      if (load.load_reps == '0) begin
         w_ld_reps = '0;
      end else begin
         w_ld_reps = load.load_reps - REP_W'(1);
      end
      w_idx_dn = r_idx - IDX_W'(1);
   end

   // Next-state and registered-output values.
   always_comb begin
      w_state   = r_state;
      w_pat     = r_pat;
      w_last    = r_last;
      w_idx     = r_idx;
      w_reps    = r_reps;
      w_c_out   = r_c_out;
      w_c_valid = r_c_valid;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_ready   = r_ready;

      unique case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               w_pat   = load.load_pattern;
               w_last  = w_ld_last;
               w_idx   = w_ld_last;
               w_reps  = w_ld_reps;
               w_ready = 1'b0;
               w_busy  = 1'b1;
               if (w_ld_len == '0) begin
                  w_state   = DONE;
                  w_done    = 1'b1;
                  w_c_valid = 1'b0;
                  w_c_out   = IDLE_LEVEL;
               end else begin
                  w_state   = SHIFT;
                  w_c_valid = 1'b1;
                  w_c_out   = load.load_pattern[w_ld_last];
               end
            end
         end

         SHIFT: begin
            if (abort) begin
               w_state   = IDLE;
               w_c_valid = 1'b0;
               w_c_out   = IDLE_LEVEL;
               w_busy    = 1'b0;
               w_ready   = 1'b1;
            end else if (bit_en) begin
               if (r_idx != '0) begin
                  w_idx   = w_idx_dn;
                  w_c_out = r_pat[w_idx_dn];
               end else if (r_reps != '0) begin
                  w_idx   = r_last;
                  w_reps  = r_reps - REP_W'(1);
                  w_c_out = r_pat[r_last];
               end else begin
                  w_state   = DONE;
                  w_done    = 1'b1;
                  w_c_valid = 1'b0;
                  w_c_out   = IDLE_LEVEL;
               end
            end
         end

         DONE: begin
            w_state   = IDLE;
            w_c_valid = 1'b0;
            w_c_out   = IDLE_LEVEL;
            w_busy    = 1'b0;
            w_ready   = 1'b1;
         end

         default: begin
            w_state   = IDLE;
            w_c_valid = 1'b0;
            w_c_out   = IDLE_LEVEL;
            w_busy    = 1'b0;
            w_ready   = 1'b1;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pat     <= '0;
         r_last    <= '0;
         r_idx     <= '0;
         r_reps    <= '0;
         r_c_out   <= IDLE_LEVEL;
         r_c_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_state   <= w_state;
         r_pat     <= w_pat;
         r_last    <= w_last;
         r_idx     <= w_idx;
         r_reps    <= w_reps;
         r_c_out   <= w_c_out;
         r_c_valid <= w_c_valid;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_ready   <= w_ready;
      end
   end

   assign load.load_ready = r_ready;
   assign c_out           = r_c_out;
   assign c_valid         = r_c_valid;
   assign busy            = r_busy;
   assign done            = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen.
// Checks {c_valid,c_out,done,busy,load_ready} each cycle.
module tb_seq_pattern_gen;

   localparam logic [4:0] S_IDLE = 5'b00001;
   localparam logic [4:0] S_DONE = 5'b00110;
   localparam logic [4:0] S_ONE  = 5'b11010;
   localparam logic [4:0] S_ZERO = 5'b10010;

   logic clk;
   logic rst_n;
   logic bit_en;
   logic abort;
   logic c_out;
   logic c_valid;
   logic busy;
   logic done;

   int n_asserts;
   int n_fail;

   seq_pattern_gen_if ld_if ();

   seq_pattern_gen dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ld_if.slave),
      .bit_en  (bit_en),
      .abort   (abort),
      .c_out   (c_out),
      .c_valid (c_valid),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [4:0] exp);
      logic [4:0] obs;
      obs = {c_valid, c_out, done, busy, ld_if.load_ready};
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b",
                tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] pat,
                       input logic [3:0] len,
                       input logic [3:0] reps);
      ld_if.load_pattern = pat;
      ld_if.load_len     = len;
      ld_if.load_reps    = reps;
      ld_if.load_valid   = 1'b1;
      step();
      ld_if.load_valid   = 1'b0;
   endtask

   initial begin
      logic [5:0] b2;
      logic [7:0] b5;
      n_asserts = 0;
      n_fail    = 0;
      rst_n     = 1'b1;
      bit_en    = 1'b0;
      abort     = 1'b0;
      ld_if.load_valid   = 1'b0;
      ld_if.load_pattern = '0;
      ld_if.load_len     = '0;
      ld_if.load_reps    = '0;
      #2 rst_n = 1'b0;
      #1 chk("reset", S_IDLE);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("idle", S_IDLE);

      // 1: 0D len4 -> 1,1,0,1 then done
      bit_en = 1'b1;
      load(8'h0D, 4'd4, 4'd1);
      chk("t1_b3", S_ONE);
      step();
      chk("t1_b2", S_ONE);
      step();
      chk("t1_b1", S_ZERO);
      step();
      chk("t1_b0", S_ONE);
      step();
      chk("t1_done", S_DONE);
      step();
      chk("t1_idle", S_IDLE);

      // 2: 05 len3 reps2 -> 1,0,1,1,0,1
      b2 = 6'b101101;
      load(8'h05, 4'd3, 4'd2);
      for (int i = 5; i >= 0; i--) begin
         chk("t2_bit", b2[i] ? S_ONE : S_ZERO);
         step();
      end
      chk("t2_done", S_DONE);
      step();
      chk("t2_idle", S_IDLE);

      // 3: stall first bit of 02 len2
      bit_en = 1'b0;
      load(8'h02, 4'd2, 4'd1);
      chk("t3_hold1", S_ONE);
      step();
      chk("t3_hold2", S_ONE);
      step();
      chk("t3_hold3", S_ONE);
      step();
      chk("t3_hold4", S_ONE);
      bit_en = 1'b1;
      step();
      chk("t3_b0", S_ZERO);
      step();
      chk("t3_done", S_DONE);
      step();
      chk("t3_idle", S_IDLE);

      // 4: abort on 2nd bit of FF len8
      load(8'hFF, 4'd8, 4'd1);
      chk("t4_b7", S_ONE);
      step();
      chk("t4_b6", S_ONE);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_abort", S_IDLE);
      step();
      chk("t4_nodone", S_IDLE);

      // abort in IDLE blocks a load
      abort = 1'b1;
      load(8'hFF, 4'd8, 4'd1);
      abort = 1'b0;
      chk("idle_abort", S_IDLE);
      step();
      chk("idle_abort2", S_IDLE);

      // 5: len0 -> done directly; len12 -> 8 bits
      load(8'hAA, 4'd0, 4'd1);
      chk("t5_len0", S_DONE);
      step();
      chk("t5_len0_idle", S_IDLE);
      b5 = 8'hA5;
      load(b5, 4'd12, 4'd1);
      for (int i = 7; i >= 0; i--) begin
         chk("t5_clamp_bit", b5[i] ? S_ONE : S_ZERO);
         step();
      end
      chk("t5_clamp_done", S_DONE);
      step();
      chk("t5_clamp_idle", S_IDLE);

      // 6: reps0 as one pass; reset mid-shift
      load(8'h01, 4'd1, 4'd0);
      chk("t6_rep0_bit", S_ONE);
      step();
      chk("t6_rep0_done", S_DONE);
      step();
      chk("t6_rep0_idle", S_IDLE);
      load(8'hFF, 4'd8, 4'd3);
      step();
      chk("t6_shift", S_ONE);
      #1 rst_n = 1'b0;
      #1 chk("t6_rst", S_IDLE);
      step();
      chk("t6_rst_hold", S_IDLE);
      rst_n = 1'b1;
      step();
      chk("t6_post_rst", S_IDLE);
      load(8'h0D, 4'd4, 4'd1);
      chk("t6_reload", S_ONE);
      step();
      step();
      chk("t6_reload_b1", S_ZERO);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
